// File: rtl/conv_host_mem_if.sv
// conv_host_mem_if: load, accelerator and dump signals between conv_host_mem and its neighbours
interface conv_host_mem_if;
    logic        load_valid;
    logic [19:0] load_data;
    logic        load_ready;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        dump_valid;
    logic        dump_ready;
    logic        dump_bank;
    logic [11:0] dump_addr;
    logic [19:0] dump_data;
    logic        done;
    logic        err;
    logic        timeout;

    modport slave (
        input  load_valid, load_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, dump_ready,
        output load_ready, ready, idata, cdata_rd, dump_valid, dump_bank, dump_addr, dump_data, done, err, timeout
    );

    modport master (
        output load_valid, load_data, busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel, dump_ready,
        input  load_ready, ready, idata, cdata_rd, dump_valid, dump_bank, dump_addr, dump_data, done, err, timeout
    );
endinterface

// File: rtl/conv_host_mem.sv
// conv_host_mem: image/layer memory responder for the CONV accelerator with a result dump port
module conv_host_mem #(
    parameter int IMG_DEPTH = 4096,
    parameter int L0_DEPTH  = 4096,
    parameter int L1_DEPTH  = 1024,
    parameter int TIMEOUT   = 200000
) (
    input logic             clk,
    input logic             reset,
    conv_host_mem_if.slave  bus
);
    localparam int L1_AW = $clog2(L1_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [11:0] IMG_LAST = 12'(IMG_DEPTH - 1);
    localparam logic [11:0] L0_LAST = 12'(L0_DEPTH - 1);
    localparam logic [11:0] L1_LAST = 12'(L1_DEPTH - 1);
    localparam logic [12:0] L1_LIM = 13'(L1_DEPTH);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {LOAD, START, SERVE, DUMP, DONE} state_t;

    logic [19:0] img [IMG_DEPTH];
    logic [19:0] l0 [L0_DEPTH];
    logic [19:0] l1 [L1_DEPTH];

    state_t state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic nbank_q, nbank_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic load_ready_q, load_ready_d;
    logic ready_q, ready_d;
    logic dump_valid_q, dump_valid_d;
    logic dump_bank_q, dump_bank_d;
    logic [11:0] dump_addr_q, dump_addr_d;
    logic [19:0] dump_data_q, dump_data_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic timeout_q, timeout_d;

    logic sel_l0, sel_l1, wr_bad, l0_we, l1_we, load_we;

    assign sel_l0 = bus.csel == 3'b001;
    assign sel_l1 = bus.csel == 3'b011;
    assign wr_bad = bus.cwr && (state_q == LOAD || !(sel_l0 || sel_l1) || (sel_l1 && {1'b0, bus.caddr_wr} >= L1_LIM));
    assign l0_we = bus.cwr && !wr_bad && sel_l0;
    assign l1_we = bus.cwr && !wr_bad && sel_l1;
    assign load_we = state_q == LOAD && load_ready_q && bus.load_valid;

    assign bus.idata = img[bus.iaddr];
    assign bus.cdata_rd = !bus.crd ? 20'd0 : sel_l0 ? l0[bus.caddr_rd] : sel_l1 ? l1[bus.caddr_rd[L1_AW-1:0]] : 20'd0;
    assign bus.load_ready = load_ready_q;
    assign bus.ready = ready_q;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_bank = dump_bank_q;
    assign bus.dump_addr = dump_addr_q;
    assign bus.dump_data = dump_data_q;
    assign bus.done = done_q;
    assign bus.err = err_q;
    assign bus.timeout = timeout_q;

    always_ff @(posedge clk) begin
        if (load_we) img[cnt_q] <= bus.load_data;
        if (l0_we) l0[bus.caddr_wr] <= bus.cdata_wr;
        if (l1_we) l1[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        nbank_d = nbank_q;
        wd_d = wd_q;
        load_ready_d = load_ready_q;
        ready_d = ready_q;
        dump_valid_d = dump_valid_q;
        dump_bank_d = dump_bank_q;
        dump_addr_d = dump_addr_q;
        dump_data_d = dump_data_q;
        done_d = 1'b0;
        err_d = err_q | wr_bad;
        timeout_d = timeout_q;
        case (state_q)
            LOAD: begin
                load_ready_d = 1'b1;
                if (load_we) begin
                    cnt_d = cnt_q + 12'd1;
                    if (cnt_q == IMG_LAST) begin
                        state_d = START;
                        cnt_d = '0;
                        load_ready_d = 1'b0;
                        ready_d = 1'b1;
                    end
                end
            end
            START: begin
                ready_d = !bus.busy;
                wd_d = '0;
                if (bus.busy) state_d = SERVE;
            end
            SERVE: begin
                wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
                timeout_d = timeout_q | (wd_d == WD_MAX);
                if (!bus.busy) begin
                    state_d = DUMP;
                    cnt_d = '0;
                    nbank_d = 1'b0;
                end
            end
            DUMP: begin
                // cnt_q/nbank_q name the next word to present, not the one on the port
                if (dump_valid_q && bus.dump_ready && dump_bank_q && dump_addr_q == L1_LAST) begin
                    state_d = DONE;
                    dump_valid_d = 1'b0;
                    done_d = 1'b1;
                end else if (!dump_valid_q || bus.dump_ready) begin
                    dump_valid_d = 1'b1;
                    dump_bank_d = nbank_q;
                    dump_addr_d = cnt_q;
                    dump_data_d = nbank_q ? l1[cnt_q[L1_AW-1:0]] : l0[cnt_q];
                    nbank_d = nbank_q | (cnt_q == L0_LAST);
                    cnt_d = (!nbank_q && cnt_q == L0_LAST) ? 12'd0 : cnt_q + 12'd1;
                end
            end
            DONE: begin
                state_d = LOAD;
                load_ready_d = 1'b1;
                cnt_d = '0;
                nbank_d = 1'b0;
                dump_bank_d = 1'b0;
                dump_addr_d = '0;
                dump_data_d = '0;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD;
            cnt_q <= '0;
            nbank_q <= 1'b0;
            wd_q <= '0;
            load_ready_q <= 1'b0;
            ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            dump_bank_q <= 1'b0;
            dump_addr_q <= '0;
            dump_data_q <= '0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            nbank_q <= nbank_d;
            wd_q <= wd_d;
            load_ready_q <= load_ready_d;
            ready_q <= ready_d;
            dump_valid_q <= dump_valid_d;
            dump_bank_q <= dump_bank_d;
            dump_addr_q <= dump_addr_d;
            dump_data_q <= dump_data_d;
            done_q <= done_d;
            err_q <= err_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: tb/tb_conv_host_mem.sv
// tb_conv_host_mem: directed vectors and multi-cycle sequences for conv_host_mem
module tb_conv_host_mem;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int failures = 0;

    conv_host_mem_if bus();

    conv_host_mem #(.TIMEOUT(1000)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  csel;
        logic        cwr;
        logic [11:0] waddr;
        logic [19:0] wdata;
        logic        crd;
        logic [11:0] raddr;
        logic [19:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit known(input logic b, input logic [11:0] a, output logic [19:0] d);
        d = 20'h0;
        if (!b && a == 12'h000) d = 20'h22222;
        else if (!b && a == 12'h123) d = 20'h12345;
        else if (b && a == 12'h000) d = 20'h55AA5;
        else if (b && a == 12'h3FF) d = 20'h0F0F0;
        else return 1'b0;
        return 1'b1;
    endfunction

    task automatic load_image(input logic [19:0] base, input bit poke);
        for (int k = 0; k < 20 && !bus.load_ready; k++) cyc(1);
        chk("load_ready_wait", 32'(bus.load_ready), 1);
        for (int i = 0; i < 4096; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data = base | 20'(i);
            if (poke) begin
                bus.cwr = (i == 100);
                bus.csel = 3'b001;
                bus.caddr_wr = 12'h123;
                bus.cdata_wr = 20'h77777;
            end
            if (i == 4095) chk("load_ready_last", 32'(bus.load_ready), 1);
            cyc(1);
        end
        bus.load_valid = 1'b0;
        bus.cwr = 1'b0;
        chk("load_ready_drop", 32'(bus.load_ready), 0);
        chk("ready_after_load", 32'(bus.ready), 1);
    endtask

    task automatic start_serve(input int hold);
        bus.busy = 1'b0;
        cyc(hold);
        chk("ready_held", 32'(bus.ready), 1);
        bus.busy = 1'b1;
        cyc(1);
        chk("ready_drop", 32'(bus.ready), 0);
    endtask

    task automatic run_dump(input bit toggle, input int stop_at, output int nxfer, output int ndone, output int bad);
        logic       exp_bank = 1'b0;
        logic [11:0] exp_addr = 12'h0;
        logic       pb = 1'b0;
        logic [11:0] pa = 12'h0;
        logic [19:0] pd = 20'h0;
        logic [19:0] kd;
        bit stall = 1'b0;
        bit rdy = 1'b1;
        nxfer = 0;
        ndone = 0;
        bad = 0;
        for (int c = 0; c < 20000; c++) begin
            bus.dump_ready = rdy;
            @(negedge clk);
            if (bus.done) ndone++;
            if (ndone != 0) break;
            if (stall && (bus.dump_valid !== 1'b1 || bus.dump_bank !== pb || bus.dump_addr !== pa || bus.dump_data !== pd)) bad++;
            if (bus.dump_valid && bus.dump_ready) begin
                if (bus.dump_bank !== exp_bank || bus.dump_addr !== exp_addr) bad++;
                if (known(bus.dump_bank, bus.dump_addr, kd) && bus.dump_data !== kd) bad++;
                if (!exp_bank && exp_addr == 12'hFFF) begin
                    exp_bank = 1'b1;
                    exp_addr = 12'h0;
                end else exp_addr = exp_addr + 12'd1;
                nxfer++;
            end
            stall = bus.dump_valid && !bus.dump_ready;
            pb = bus.dump_bank;
            pa = bus.dump_addr;
            pd = bus.dump_data;
            if (stop_at != 0 && nxfer == stop_at) break;
            @(posedge clk);
            #1;
            if (toggle) rdy = !rdy;
        end
    endtask

    initial begin
        int nx, nd, nb;
        vt = '{
            '{"wr_l0_123",   3'b001, 1'b1, 12'h123, 20'hABCDE, 1'b0, 12'h000, 20'h00000, 1'b0},
            '{"rd_l0_123",   3'b001, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h123, 20'hABCDE, 1'b0},
            '{"wr_rd_same",  3'b001, 1'b1, 12'h123, 20'h12345, 1'b1, 12'h123, 20'hABCDE, 1'b0},
            '{"rd_l0_new",   3'b001, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h123, 20'h12345, 1'b0},
            '{"wr_l0_000",   3'b001, 1'b1, 12'h000, 20'h22222, 1'b0, 12'h000, 20'h00000, 1'b0},
            '{"wr_l1_000",   3'b011, 1'b1, 12'h000, 20'h55AA5, 1'b0, 12'h000, 20'h00000, 1'b0},
            '{"rd_l1_000",   3'b011, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h000, 20'h55AA5, 1'b0},
            '{"wr_l1_3ff",   3'b011, 1'b1, 12'h3FF, 20'h0F0F0, 1'b1, 12'h000, 20'h55AA5, 1'b0},
            '{"rd_l1_wrap",  3'b011, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h7FF, 20'h0F0F0, 1'b0},
            '{"rd_crd0",     3'b001, 1'b0, 12'h000, 20'h00000, 1'b0, 12'h123, 20'h00000, 1'b0},
            '{"rd_csel010",  3'b010, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h123, 20'h00000, 1'b0},
            '{"wr_l1_oob",   3'b011, 1'b1, 12'h400, 20'hFFFFF, 1'b1, 12'h000, 20'h55AA5, 1'b1},
            '{"rd_l1_oob",   3'b011, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h000, 20'h55AA5, 1'b1},
            '{"wr_csel010",  3'b010, 1'b1, 12'h000, 20'h11111, 1'b0, 12'h000, 20'h00000, 1'b1},
            '{"rd_l0_000",   3'b001, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h000, 20'h22222, 1'b1},
            '{"rd_l1_3ff",   3'b011, 1'b0, 12'h000, 20'h00000, 1'b1, 12'h3FF, 20'h0F0F0, 1'b1}
        };
        bus.load_valid = 1'b0;
        bus.load_data = '0;
        bus.busy = 1'b0;
        bus.iaddr = '0;
        bus.cwr = 1'b0;
        bus.caddr_wr = '0;
        bus.cdata_wr = '0;
        bus.crd = 1'b0;
        bus.caddr_rd = '0;
        bus.csel = '0;
        bus.dump_ready = 1'b0;
        cyc(3);
        @(negedge clk);
        chk("rst_load_ready", 32'(bus.load_ready), 0);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_dump_valid", 32'(bus.dump_valid), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_err", 32'(bus.err), 0);
        chk("rst_timeout", 32'(bus.timeout), 0);
        reset = 1'b1;
        cyc(1);

        load_image(20'h00000, 1'b0);
        bus.iaddr = 12'h0A5;
        #1 chk("idata_0a5", 32'(bus.idata), 'h000A5);
        bus.iaddr = 12'hFFF;
        #1 chk("idata_fff", 32'(bus.idata), 'h00FFF);
        start_serve(50);
        foreach (vt[i]) begin
            bus.csel = vt[i].csel;
            bus.cwr = vt[i].cwr;
            bus.caddr_wr = vt[i].waddr;
            bus.cdata_wr = vt[i].wdata;
            bus.crd = vt[i].crd;
            bus.caddr_rd = vt[i].raddr;
            @(negedge clk);
            chk({vt[i].name, "_rd"}, 32'(bus.cdata_rd), 32'(vt[i].exp_rd));
            cyc(1);
            chk({vt[i].name, "_err"}, 32'(bus.err), 32'(vt[i].exp_err));
        end
        bus.cwr = 1'b0;
        bus.crd = 1'b0;
        bus.csel = 3'b000;
        chk("timeout_short_serve", 32'(bus.timeout), 0);
        bus.busy = 1'b0;
        cyc(1);
        chk("dump_entry_idle", 32'(bus.dump_valid), 0);
        run_dump(1'b1, 0, nx, nd, nb);
        chk("dump1_xfers", 32'(nx), 5120);
        chk("dump1_done", 32'(nd), 1);
        chk("dump1_order", 32'(nb), 0);
        cyc(1);
        chk("dump1_done_once", 32'(bus.done), 0);
        chk("dump1_load_ready", 32'(bus.load_ready), 1);

        load_image(20'hF0000, 1'b1);
        chk("err_load_write", 32'(bus.err), 1);
        bus.iaddr = 12'h0A5;
        #1 chk("idata2_0a5", 32'(bus.idata), 'hF00A5);
        start_serve(5);
        bus.csel = 3'b001;
        bus.crd = 1'b1;
        bus.caddr_rd = 12'h123;
        #1 chk("load_write_ignored", 32'(bus.cdata_rd), 'h12345);
        bus.crd = 1'b0;
        cyc(900);
        chk("timeout_before", 32'(bus.timeout), 0);
        cyc(200);
        chk("timeout_after", 32'(bus.timeout), 1);
        bus.busy = 1'b0;
        cyc(1);
        run_dump(1'b1, 2000, nx, nd, nb);
        chk("dump2_xfers", 32'(nx), 2000);
        chk("dump2_order", 32'(nb), 0);
        chk("dump2_valid_pre", 32'(bus.dump_valid), 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_load_ready", 32'(bus.load_ready), 0);
        chk("mid_rst_ready", 32'(bus.ready), 0);
        chk("mid_rst_dump_valid", 32'(bus.dump_valid), 0);
        chk("mid_rst_dump_bank", 32'(bus.dump_bank), 0);
        chk("mid_rst_dump_addr", 32'(bus.dump_addr), 0);
        chk("mid_rst_dump_data", 32'(bus.dump_data), 0);
        chk("mid_rst_done", 32'(bus.done), 0);
        chk("mid_rst_err", 32'(bus.err), 0);
        chk("mid_rst_timeout", 32'(bus.timeout), 0);
        cyc(2);
        reset = 1'b1;
        cyc(1);

        load_image(20'h5A000, 1'b0);
        bus.iaddr = 12'h0A5;
        #1 chk("idata3_0a5", 32'(bus.idata), 'h5A0A5);
        bus.iaddr = 12'hFFF;
        #1 chk("idata3_fff", 32'(bus.idata), 'h5AFFF);
        start_serve(3);
        cyc(5);
        chk("timeout_run3", 32'(bus.timeout), 0);
        bus.busy = 1'b0;
        cyc(1);
        run_dump(1'b0, 0, nx, nd, nb);
        chk("dump3_xfers", 32'(nx), 5120);
        chk("dump3_done", 32'(nd), 1);
        chk("dump3_order", 32'(nb), 0);
        cyc(1);
        chk("dump3_done_once", 32'(bus.done), 0);
        chk("dump3_load_ready", 32'(bus.load_ready), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
